tuner_sweep_ctrl: RTL

//  Sequences a microring tuner sweep. Steps the ring tuning DAC code across the full range and waits
//  a settle time at each step. Requests a thru/drop power sample from tuner_pwr_detect_phy over
//  val/rdy and tracks the extremum (min thru / max drop). Parks the DAC at the resonance code it found.

---
 rtl/tuner_pkg.sv | 28 ++
 rtl/tuner_sweep_ctrl_if.sv | 36 +++
 rtl/tuner_settle_timer.sv | 41 ++++
 rtl/tuner_sweep_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tuner_pkg.sv
// Shared definitions for the microring tuner blocks.
// Holds the default converter widths shared with the adc/pwr_detect blocks,
// the sweep FSM state type and the matching state encodings used by the
// controller's state register.
package tuner_pkg;

    // Default widths shared with the ADC and power-detect path.
    localparam int TUNER_DAC_WIDTH = 8;
    localparam int TUNER_ADC_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        REQ    = 3'd2,
        WAIT   = 3'd3,
        EVAL   = 3'd4,
        DONE   = 3'd5
    } tuner_sweep_state_e;

    // Plain encodings for the state register (same values as the enum).
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_REQ    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_EVAL   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/tuner_sweep_ctrl_if.sv
// Power-measurement handshake between the sweep controller (master) and
// tuner_pwr_detect_phy (slave).
//   pwr_read_val / pwr_read_rdy     : read request, controller -> detector
//   pwr_detect_val / pwr_detect_rdy : detected power, detector -> controller
//   pwr_detected                    : detected power value (ADC_WIDTH bits)
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where val and rdy are both high; once val is raised it stays high (with its
// payload stable) until that transfer; rdy may toggle freely and never waits
// on val.
interface tuner_sweep_ctrl_if
    import tuner_pkg::*;
#(
    parameter int ADC_WIDTH = TUNER_ADC_WIDTH
);
    logic                 pwr_read_val;
    logic                 pwr_read_rdy;
    logic                 pwr_detect_val;
    logic                 pwr_detect_rdy;
    logic [ADC_WIDTH-1:0] pwr_detected;

    modport master (
        output pwr_read_val,
        input  pwr_read_rdy,
        input  pwr_detect_val,
        output pwr_detect_rdy,
        input  pwr_detected
    );

    modport slave (
        input  pwr_read_val,
        output pwr_read_rdy,
        output pwr_detect_val,
        input  pwr_detect_rdy,
        output pwr_detected
    );
endinterface

// File: rtl/tuner_settle_timer.sv
// Settle-time down-counter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : reload with SETTLE_CYCLES-1 (takes priority)
//   i_run          : count down by one while non-zero
//   o_expire       : counter is at zero
// Loading on entry to SETTLE and running while in SETTLE gives exactly
// SETTLE_CYCLES cycles in SETTLE, with o_expire high on the last of them.
module tuner_settle_timer #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expire
);
    localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = LOAD_VAL;
        end else if (i_run && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = (cnt_q == '0);
endmodule

// File: rtl/tuner_sweep_ctrl.sv
// Microring tuner sweep controller.
// Steps the heater DAC code from 0 to 2^DAC_WIDTH-1 in STEP increments, holds
// each code for SETTLE_CYCLES, requests one power sample per code and tracks
// the extremum (minimum when SEARCH_MIN=1, maximum otherwise). At the end of a
// complete sweep it publishes the best code/power and parks the DAC there.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_sweep_start      start request (accepted in IDLE when abort is low)
//   i_sweep_abort      abandon the current sweep, back to IDLE
//   o_dac_code         tuning code to the ring heater DAC
//   pwr_if             power read/detect handshake (master side)
//   o_busy             high in every state except IDLE
//   o_done             one-cycle pulse on normal sweep completion
//   o_lock_code/_pwr   result of the last completed sweep
//   o_state            current FSM state (debug)
module tuner_sweep_ctrl
    import tuner_pkg::*;
#(
    parameter int DAC_WIDTH     = TUNER_DAC_WIDTH,
    parameter int ADC_WIDTH     = TUNER_ADC_WIDTH,
    parameter int SETTLE_CYCLES = 16,
    parameter int STEP          = 1,
    parameter int SEARCH_MIN    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sweep_start,
    input  logic                 i_sweep_abort,
    output logic [DAC_WIDTH-1:0] o_dac_code,
    tuner_sweep_ctrl_if.master   pwr_if,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [DAC_WIDTH-1:0] o_lock_code,
    output logic [ADC_WIDTH-1:0] o_lock_pwr,
    output tuner_sweep_state_e   o_state
);
    localparam logic [DAC_WIDTH:0] CODE_MAX = {1'b0, {DAC_WIDTH{1'b1}}};
    localparam logic [DAC_WIDTH:0] STEP_W   = (DAC_WIDTH + 1)'(STEP);

    logic [2:0]           state_q, state_d;
    logic [DAC_WIDTH-1:0] code_q, code_d;
    logic [DAC_WIDTH-1:0] best_code_q, best_code_d;
    logic [ADC_WIDTH-1:0] best_pwr_q, best_pwr_d;
    logic [ADC_WIDTH-1:0] sample_q, sample_d;
    logic                 first_q, first_d;
    logic [DAC_WIDTH-1:0] lock_code_q, lock_code_d;
    logic [ADC_WIDTH-1:0] lock_pwr_q, lock_pwr_d;

    logic                 timer_load;
    logic                 timer_expire;
    logic                 take;
    logic [DAC_WIDTH:0]   next_code;

    tuner_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (timer_load),
        .i_run    (state_q == S_SETTLE),
        .o_expire (timer_expire)
    );

    // Strict compare: on a tie the earlier (lower) code is kept.
    assign take = first_q ||
                  ((SEARCH_MIN != 0) ? (sample_q < best_pwr_q) : (sample_q > best_pwr_q));

    // One extra bit so the last step is detected instead of wrapping.
    assign next_code = {1'b0, code_q} + STEP_W;

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        best_code_d = best_code_q;
        best_pwr_d  = best_pwr_q;
        sample_d    = sample_q;
        first_d     = first_q;
        lock_code_d = lock_code_q;
        lock_pwr_d  = lock_pwr_q;
        timer_load  = 1'b0;

        if ((state_q != S_IDLE) && i_sweep_abort) begin
            // Abort leaves the DAC code and the published result untouched.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_sweep_start && !i_sweep_abort) begin
                        code_d     = '0;
                        first_d    = 1'b1;
                        timer_load = 1'b1;
                        state_d    = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (timer_expire) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (pwr_if.pwr_read_rdy) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pwr_if.pwr_detect_val) begin
                        sample_d = pwr_if.pwr_detected;
                        state_d  = S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (take) begin
                        best_pwr_d  = sample_q;
                        best_code_d = code_q;
                        first_d     = 1'b0;
                    end
                    if (next_code > CODE_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        code_d     = next_code[DAC_WIDTH-1:0];
                        timer_load = 1'b1;
                        state_d    = S_SETTLE;
                    end
                end
                S_DONE: begin
                    lock_code_d = best_code_q;
                    lock_pwr_d  = best_pwr_q;
                    code_d      = best_code_q;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            best_code_q <= '0;
            best_pwr_q  <= '0;
            sample_q    <= '0;
            first_q     <= 1'b0;
            lock_code_q <= '0;
            lock_pwr_q  <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            best_code_q <= best_code_d;
            best_pwr_q  <= best_pwr_d;
            sample_q    <= sample_d;
            first_q     <= first_d;
            lock_code_q <= lock_code_d;
            lock_pwr_q  <= lock_pwr_d;
        end
    end

    assign o_dac_code            = code_q;
    assign pwr_if.pwr_read_val   = (state_q == S_REQ);
    assign pwr_if.pwr_detect_rdy = (state_q == S_WAIT);
    assign o_busy                = (state_q != S_IDLE);
    assign o_done                = (state_q == S_DONE) && !i_sweep_abort;
    assign o_lock_code           = lock_code_q;
    assign o_lock_pwr            = lock_pwr_q;
    assign o_state               = tuner_sweep_state_e'(state_q);
endmodule
